sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Arbitrates NumReq requesters onto a single SRAM port and
//               routes read responses back in order.
//               - Combinational arbitration with no added grant latency.
//               - Round-robin priority by default. When SRAM_ARB_FIXED_PRIO_EN
//                 is defined, the lowest eligible index wins instead.
//               - An in-order ID FIFO with depth Outstanding records which
//                 requester owns each accepted read.
//               - Reads are blocked while that FIFO is full. Writes still
//                 pass.
//               - spurious_o is a sticky flag. It records any SRAM response
//                 that arrives while no read is tracked.
// Ports       : clk_i, rst_ni (sync, active-low)
//               req_i/gnt_o/we_i/addr_i/wdata_i/wmask_i : requester side
//               rdata_o/rvalid_o/rerror_o                : response side
//               sram_*                                   : SRAM side
//               spurious_o                               : sticky error flag
// Config      : `define SRAM_ARB_FIXED_PRIO_EN for fixed-priority arbitration
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int NumReq      = 2,
    parameter int SramAw      = 12,
    parameter int SramDw      = 32,
    parameter int Outstanding = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumReq-1:0]          req_i,
    output logic [NumReq-1:0]          gnt_o,
    input  logic [NumReq-1:0]          we_i,
    input  logic [NumReq*SramAw-1:0]   addr_i,
    input  logic [NumReq*SramDw-1:0]   wdata_i,
    input  logic [NumReq*SramDw-1:0]   wmask_i,
    output logic [SramDw-1:0]          rdata_o,
    output logic [NumReq-1:0]          rvalid_o,
    output logic [NumReq*2-1:0]        rerror_o,
    output logic                       sram_req_o,
    input  logic                       sram_gnt_i,
    output logic                       sram_we_o,
    output logic [SramAw-1:0]          sram_addr_o,
    output logic [SramDw-1:0]          sram_wdata_o,
    output logic [SramDw-1:0]          sram_wmask_o,
    input  logic [SramDw-1:0]          sram_rdata_i,
    input  logic                       sram_rvalid_i,
    input  logic [1:0]                 sram_rerror_i,
    output logic                       spurious_o
);

    localparam int IDX_W = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int PTR_W = (Outstanding > 1) ? $clog2(Outstanding) : 1;
    localparam int CNT_W = $clog2(Outstanding + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] fifo_id_q [Outstanding];
    logic [PTR_W-1:0] fifo_rd_q, fifo_rd_d;
    logic [PTR_W-1:0] fifo_wr_q, fifo_wr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic             spurious_q, spurious_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic              fifo_full;
    logic              fifo_empty;
    logic [NumReq-1:0] eligible;
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              accept;
    logic              push;
    logic              pop;
    logic [IDX_W-1:0]  head_id;

    assign fifo_full  = (fifo_cnt_q == CNT_W'(Outstanding));
    assign fifo_empty = (fifo_cnt_q == '0);

    // Reads need a free FIFO slot to be eligible. Writes never occupy a slot.
    assign eligible = req_i & (we_i | {NumReq{~fifo_full}});

    // Cyclic search upward from ptr_q. In fixed-priority mode ptr_q stays
    // at 0, so the same search returns the lowest eligible index.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NumReq; k++) begin
            idx = (int'(ptr_q) + k) % NumReq;
            if (!win_found && eligible[IDX_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
    end

    assign accept  = win_found & sram_gnt_i;
    assign push    = accept & ~we_i[win_idx];
    assign pop     = sram_rvalid_i & ~fifo_empty;
    assign head_id = fifo_id_q[fifo_rd_q];

    // Winner's fields to the SRAM. All fields are zero when nothing wins.
    always_comb begin
        sram_req_o   = win_found;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        gnt_o        = '0;
        if (win_found) begin
            sram_we_o      = we_i[win_idx];
            sram_addr_o    = addr_i[win_idx*SramAw +: SramAw];
            sram_wdata_o   = wdata_i[win_idx*SramDw +: SramDw];
            sram_wmask_o   = wmask_i[win_idx*SramDw +: SramDw];
            gnt_o[win_idx] = sram_gnt_i;
        end
    end

    // Route the response to the requester at the FIFO head.
    always_comb begin
        rvalid_o = '0;
        rerror_o = '0;
        if (pop) begin
            rvalid_o[head_id]          = 1'b1;
            rerror_o[head_id*2 +: 2]   = sram_rerror_i;
        end
    end

    assign rdata_o    = sram_rvalid_i ? sram_rdata_i : '0;
    assign spurious_o = spurious_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        ptr_d = '0;
`else
        if (accept) begin
            ptr_d = (win_idx == IDX_W'(NumReq - 1)) ? '0 : win_idx + 1'b1;
        end
`endif

        fifo_wr_d = fifo_wr_q;
        if (push) begin
            fifo_wr_d = (fifo_wr_q == PTR_W'(Outstanding - 1)) ? '0 : fifo_wr_q + 1'b1;
        end

        fifo_rd_d = fifo_rd_q;
        if (pop) begin
            fifo_rd_d = (fifo_rd_q == PTR_W'(Outstanding - 1)) ? '0 : fifo_rd_q + 1'b1;
        end

        // A simultaneous push and pop leaves the count unchanged.
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (pop && !push) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end

        spurious_d = spurious_q | (sram_rvalid_i & fifo_empty);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            fifo_rd_q  <= '0;
            fifo_wr_q  <= '0;
            fifo_cnt_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            spurious_q <= spurious_d;
        end
    end

    // ID storage needs no reset. Entries are only read while the count
    // marks them valid.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            fifo_id_q[fifo_wr_q] <= win_idx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_arbiter
// Description : Self-checking bench for sram_arbiter (NumReq=2, Outstanding=2)
//               with directed scenarios followed by random traffic, compared
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int N   = 2;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int OUT = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata, wmask;
    logic            sgnt;
    logic [DW-1:0]   srdata;
    logic            srvalid;
    logic [1:0]      srerr;

    logic [N-1:0]    gnt_o, rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic [2*N-1:0]  rerror_o;
    logic            sram_req_o, sram_we_o, spurious_o;
    logic [AW-1:0]   sram_addr_o;
    logic [DW-1:0]   sram_wdata_o, sram_wmask_o;

    sram_arbiter #(.NumReq(N), .SramAw(AW), .SramDw(DW), .Outstanding(OUT)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt_o),
        .we_i         (we),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .wmask_i      (wmask),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .rerror_o     (rerror_o),
        .sram_req_o   (sram_req_o),
        .sram_gnt_i   (sgnt),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_wmask_o (sram_wmask_o),
        .sram_rdata_i (srdata),
        .sram_rvalid_i(srvalid),
        .sram_rerror_i(srerr),
        .spurious_o   (spurious_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: round-robin pointer, queue of read owners, sticky flag
    int m_ptr;
    int m_q[$];
    bit m_spur;

    // DUT values seen at the most recent check point, for directed checks
    logic [N-1:0] obs_gnt, obs_rv;
    logic         obs_spur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        req = '0; we = '0; addr = '0; wdata = '0; wmask = '0;
        sgnt = 1'b0; srdata = '0; srvalid = 1'b0; srerr = '0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        int             w;
        bit             full, pop;
        int             head;
        logic [N-1:0]   e_gnt, e_rv;
        logic [2*N-1:0] e_err;
        logic           e_we;
        logic [AW-1:0]  e_addr;
        logic [DW-1:0]  e_wd, e_wm;
        @(negedge clk);
        full = (m_q.size() == OUT);
        w    = -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (w < 0 && req[i] && (we[i] || !full)) w = i;
        end
        e_gnt  = (w >= 0 && sgnt) ? N'(1) << w : '0;
        e_we   = (w >= 0) ? we[w] : 1'b0;
        e_addr = (w >= 0) ? addr[w*AW +: AW] : '0;
        e_wd   = (w >= 0) ? wdata[w*DW +: DW] : '0;
        e_wm   = (w >= 0) ? wmask[w*DW +: DW] : '0;
        pop    = srvalid && (m_q.size() > 0);
        head   = pop ? m_q[0] : 0;
        e_rv   = pop ? N'(1) << head : '0;
        e_err  = pop ? (2*N)'(srerr) << (2*head) : '0;

        chk("gnt",      64'(gnt_o),        64'(e_gnt));
        chk("sram_req", 64'(sram_req_o),   64'(w >= 0));
        chk("sram_we",  64'(sram_we_o),    64'(e_we));
        chk("addr",     64'(sram_addr_o),  64'(e_addr));
        chk("wdata",    64'(sram_wdata_o), 64'(e_wd));
        chk("wmask",    64'(sram_wmask_o), 64'(e_wm));
        chk("rdata",    64'(rdata_o),      64'(srvalid ? srdata : '0));
        chk("rvalid",   64'(rvalid_o),     64'(e_rv));
        chk("rerror",   64'(rerror_o),     64'(e_err));
        chk("spurious", 64'(spurious_o),   64'(m_spur));
        obs_gnt  = gnt_o;
        obs_rv   = rvalid_o;
        obs_spur = spurious_o;

        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0;
            m_q.delete();
            m_spur = 1'b0;
        end else begin
            if (srvalid && m_q.size() == 0) m_spur = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (w >= 0 && sgnt) begin
`ifndef SRAM_ARB_FIXED_PRIO_EN
                m_ptr = (w + 1) % N;
`endif
                if (!we[w]) m_q.push_back(w);
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        // Initial reset without checks (DUT state is unknown before it).
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_ptr  = 0;
        m_spur = 1'b0;
        m_q.delete();

        // Reset state: every output zero with inputs idle
        step();
        chk("rst_gnt",  64'(obs_gnt),  64'(0));
        chk("rst_spur", 64'(obs_spur), 64'(0));

        // Two readers, always granted, one-cycle read latency
        req = 2'b11; we = 2'b00; sgnt = 1'b1;
        addr = 24'h456123; wdata = {32'hBBBB_0001, 32'hAAAA_0000}; wmask = '1;
        for (int i = 0; i < 4; i++) begin
            srvalid = (i > 0);
            srdata  = $urandom;
            srerr   = 2'($urandom);
            step();
`ifdef SRAM_ARB_FIXED_PRIO_EN
            chk("alt_gnt", 64'(obs_gnt), 64'(2'b01));
`else
            chk("alt_gnt", 64'(obs_gnt), 64'((i % 2) ? 2'b10 : 2'b01));
            if (i > 0) chk("alt_rvalid", 64'(obs_rv), 64'(((i - 1) % 2) ? 2'b10 : 2'b01));
`endif
        end
        req = '0; srvalid = 1'b1; step();
        srvalid = 1'b0; step();

        // Outstanding limit: third read blocked, concurrent write passes
        do_reset();
        req = 2'b01; we = 2'b00; sgnt = 1'b1;
        step(); step();
        req = 2'b11; we = 2'b10; step();
        chk("full_write_gnt", 64'(obs_gnt), 64'(2'b10));
        req = 2'b01; we = 2'b00; srvalid = 1'b1; srdata = 32'hCAFE_F00D; step();
        chk("full_read_blocked", 64'(obs_gnt), 64'(2'b00));
        chk("full_first_rvalid", 64'(obs_rv),  64'(2'b01));
        srvalid = 1'b0; step();
        chk("full_unblocked", 64'(obs_gnt), 64'(2'b01));
        req = '0; srvalid = 1'b1; step(); step();
        chk("drain_rvalid", 64'(obs_rv), 64'(2'b01));

        // Response with nothing outstanding
        srvalid = 1'b1; step();
        chk("spur_no_rvalid", 64'(obs_rv), 64'(0));
        srvalid = 1'b0; step();
        chk("spur_set", 64'(obs_spur), 64'(1));
        step();
        chk("spur_sticky", 64'(obs_spur), 64'(1));

        // Reset forgets outstanding reads
        do_reset();
        req = 2'b01; we = 2'b00; sgnt = 1'b1; step(); step();
        rst_n = 1'b0; req = '0; step();
        rst_n = 1'b1; srvalid = 1'b1; step();
        chk("post_rst_no_rvalid", 64'(obs_rv), 64'(0));
        srvalid = 1'b0; step();
        chk("post_rst_spur", 64'(obs_spur), 64'(1));

        // SRAM stall holds pointer; first grant goes to preferred requester
        do_reset();
        req = 2'b01; we = 2'b01; sgnt = 1'b1; step();
        req = 2'b11; we = 2'b11; sgnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_gnt", 64'(obs_gnt), 64'(0));
        end
        sgnt = 1'b1; step();
`ifdef SRAM_ARB_FIXED_PRIO_EN
        chk("stall_release", 64'(obs_gnt), 64'(2'b01));
`else
        chk("stall_release", 64'(obs_gnt), 64'(2'b10));
`endif

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            req     = N'($urandom);
            we      = N'($urandom);
            addr    = (N*AW)'($urandom);
            wdata   = {$urandom, $urandom};
            wmask   = {$urandom, $urandom};
            sgnt    = ($urandom_range(0, 3) != 0);
            srvalid = ($urandom_range(0, 2) == 0);
            srdata  = $urandom;
            srerr   = 2'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
